// File: rtl/cp0_regfile_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, bit positions
// and mtc0 write masks used by the register file and its timer.
package cp0_regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned INT_W  = 6;
  localparam int unsigned EXC_W  = 5;

  localparam logic [ADDR_W-1:0] CP0_BADVADDR = 5'd8;
  localparam logic [ADDR_W-1:0] CP0_COUNT    = 5'd9;
  localparam logic [ADDR_W-1:0] CP0_COMPARE  = 5'd11;
  localparam logic [ADDR_W-1:0] CP0_STATUS   = 5'd12;
  localparam logic [ADDR_W-1:0] CP0_CAUSE    = 5'd13;
  localparam logic [ADDR_W-1:0] CP0_EPC      = 5'd14;
  localparam logic [ADDR_W-1:0] CP0_PRID     = 5'd15;

  localparam logic [DATA_W-1:0] EXC_INT  = 32'h0000_0001;
  localparam logic [DATA_W-1:0] EXC_ADEL = 32'h0000_0004;
  localparam logic [DATA_W-1:0] EXC_ADES = 32'h0000_0005;
  localparam logic [DATA_W-1:0] EXC_SYS  = 32'h0000_0008;
  localparam logic [DATA_W-1:0] EXC_BP   = 32'h0000_0009;
  localparam logic [DATA_W-1:0] EXC_RI   = 32'h0000_000a;
  localparam logic [DATA_W-1:0] EXC_OV   = 32'h0000_000c;
  localparam logic [DATA_W-1:0] EXC_ERET = 32'h0000_000e;

  localparam logic [EXC_W-1:0] EXCCODE_INT = 5'h00;

  localparam int unsigned STATUS_IE    = 0;
  localparam int unsigned STATUS_EXL   = 1;
  localparam int unsigned CAUSE_EXC_LO = 2;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_BD     = 31;

  localparam logic [DATA_W-1:0] STATUS_WMASK = 32'h0000_FF03;
  localparam logic [DATA_W-1:0] CAUSE_WMASK  = 32'h0000_0300;

  // True for codes that commit an exception (eret and unknown codes excluded).
  function automatic logic is_exc(input logic [DATA_W-1:0] code);
    logic r;
    r = 1'b0;
    case (code)
      EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS,
      EXC_BP, EXC_RI, EXC_OV: r = 1'b1;
      default:                r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [EXC_W-1:0] exc_code(input logic [DATA_W-1:0] code);
    return (code == EXC_INT) ? EXCCODE_INT : code[EXC_W-1:0];
  endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// mtc0/mfc0 access bus between the pipeline and the CP0 register file.
interface cp0_regfile_if;
  import cp0_regfile_pkg::*;

  logic              we_i;
  logic [ADDR_W-1:0] waddr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [ADDR_W-1:0] raddr_i;
  logic [DATA_W-1:0] rdata_o;

  modport master (output we_i, waddr_i, wdata_i, raddr_i, input rdata_o);
  modport slave  (input we_i, waddr_i, wdata_i, raddr_i, output rdata_o);
endinterface

// File: rtl/cp0_regfile_timer.sv
// Count/Compare timer: Count advances at half clock rate, timer interrupt
// is sticky until Compare is rewritten.
module cp0_regfile_timer
  import cp0_regfile_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_count_we,
  input  logic              i_compare_we,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_count,
  output logic [DATA_W-1:0] o_compare,
  output logic              o_timer_int
);

  logic              r_tick;
  logic [DATA_W-1:0] r_count;
  logic [DATA_W-1:0] r_compare;
  logic              r_timer_int;
  logic [DATA_W-1:0] w_count_nxt;
  logic              w_hit;

  assign w_count_nxt = i_count_we ? i_wdata : (r_count + DATA_W'(r_tick));
  assign w_hit       = (w_count_nxt == r_compare) && (r_compare != '0);

  // Compare write clears the interrupt even when a match happens that cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_tick      <= 1'b0;
      r_count     <= '0;
      r_compare   <= '0;
      r_timer_int <= 1'b0;
    end else begin
      r_tick  <= ~r_tick;
      r_count <= w_count_nxt;
      if (i_compare_we) begin
        r_compare   <= i_wdata;
        r_timer_int <= 1'b0;
      end else if (w_hit) begin
        r_timer_int <= 1'b1;
      end
    end
  end

  assign o_count     = r_count;
  assign o_compare   = r_compare;
  assign o_timer_int = r_timer_int;

endmodule

// File: rtl/cp0_regfile.sv
// CP0 register file: exception commit into EPC/Cause/Status/BadVAddr,
// masked mtc0 writes, combinational mfc0 reads and the Count/Compare timer.
module cp0_regfile
  import cp0_regfile_pkg::*;
#(
  parameter logic [DATA_W-1:0] STATUS_RST = 32'h0040_0000,
  parameter logic [DATA_W-1:0] PRID_VAL   = 32'h0000_4220
)(
  input  logic              clk,
  input  logic              resetn,
  cp0_regfile_if.slave      bus,
  input  logic [INT_W-1:0]  int_i,
  input  logic [DATA_W-1:0] excepttype_i,
  input  logic [DATA_W-1:0] pc_i,
  input  logic              in_delayslot_i,
  input  logic [DATA_W-1:0] bad_addr_i,
  output logic [DATA_W-1:0] status_o,
  output logic [DATA_W-1:0] cause_o,
  output logic [DATA_W-1:0] epc_o,
  output logic [DATA_W-1:0] count_o,
  output logic [DATA_W-1:0] compare_o,
  output logic [DATA_W-1:0] badvaddr_o,
  output logic              timer_int_o
);

  logic [DATA_W-1:0] r_status;
  logic [DATA_W-1:0] r_cause;
  logic [DATA_W-1:0] r_epc;
  logic [DATA_W-1:0] r_badvaddr;

  logic [DATA_W-1:0] w_status_nxt;
  logic [DATA_W-1:0] w_cause_nxt;
  logic [DATA_W-1:0] w_epc_nxt;
  logic [DATA_W-1:0] w_badvaddr_nxt;
  logic [DATA_W-1:0] w_count;
  logic [DATA_W-1:0] w_compare;
  logic [DATA_W-1:0] w_rdata;
  logic              w_timer_int;
  logic              w_exc;
  logic              w_eret;
  logic              w_wr;

  // An excepting or returning instruction squashes its own mtc0.
  assign w_exc  = is_exc(excepttype_i);
  assign w_eret = (excepttype_i == EXC_ERET);
  assign w_wr   = bus.we_i && !w_exc && !w_eret;

  cp0_regfile_timer u_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_count_we   (w_wr && (bus.waddr_i == CP0_COUNT)),
    .i_compare_we (w_wr && (bus.waddr_i == CP0_COMPARE)),
    .i_wdata      (bus.wdata_i),
    .o_count      (w_count),
    .o_compare    (w_compare),
    .o_timer_int  (w_timer_int)
  );

  always_comb begin
    w_status_nxt   = r_status;
    w_cause_nxt    = r_cause;
    w_epc_nxt      = r_epc;
    w_badvaddr_nxt = r_badvaddr;

    w_cause_nxt[CAUSE_IP_HI:CAUSE_IP_LO] = {int_i[5] | w_timer_int, int_i[4:0]};

    if (w_wr) begin
      case (bus.waddr_i)
        CP0_STATUS: w_status_nxt = (r_status & ~STATUS_WMASK) | (bus.wdata_i & STATUS_WMASK);
        CP0_CAUSE:  w_cause_nxt  = (w_cause_nxt & ~CAUSE_WMASK) | (bus.wdata_i & CAUSE_WMASK);
        CP0_EPC:    w_epc_nxt    = bus.wdata_i;
        default:    ;
      endcase
    end

    // Nested exceptions (EXL already set) keep the original return point.
    if (w_exc) begin
      if (!r_status[STATUS_EXL]) begin
        w_epc_nxt             = in_delayslot_i ? (pc_i - 32'd4) : pc_i;
        w_cause_nxt[CAUSE_BD] = in_delayslot_i;
      end
      w_status_nxt[STATUS_EXL]                = 1'b1;
      w_cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO]  = exc_code(excepttype_i);
      if ((excepttype_i == EXC_ADEL) || (excepttype_i == EXC_ADES)) begin
        w_badvaddr_nxt = bad_addr_i;
      end
    end else if (w_eret) begin
      w_status_nxt[STATUS_EXL] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_status   <= STATUS_RST;
      r_cause    <= '0;
      r_epc      <= '0;
      r_badvaddr <= '0;
    end else begin
      r_status   <= w_status_nxt;
      r_cause    <= w_cause_nxt;
      r_epc      <= w_epc_nxt;
      r_badvaddr <= w_badvaddr_nxt;
    end
  end

  always_comb begin
    w_rdata = '0;
    case (bus.raddr_i)
      CP0_BADVADDR: w_rdata = r_badvaddr;
      CP0_COUNT:    w_rdata = w_count;
      CP0_COMPARE:  w_rdata = w_compare;
      CP0_STATUS:   w_rdata = r_status;
      CP0_CAUSE:    w_rdata = r_cause;
      CP0_EPC:      w_rdata = r_epc;
      CP0_PRID:     w_rdata = PRID_VAL;
      default:      w_rdata = '0;
    endcase
  end

  assign bus.rdata_o = w_rdata;
  assign status_o    = r_status;
  assign cause_o     = r_cause;
  assign epc_o       = r_epc;
  assign count_o     = w_count;
  assign compare_o   = w_compare;
  assign badvaddr_o  = r_badvaddr;
  assign timer_int_o = w_timer_int;

endmodule

// File: tb/tb_cp0_regfile.sv
// Bench for cp0_regfile: directed stimulus, a behavioural CP0 model checked
// every cycle, plus hand-computed expectations at key points.
module tb_cp0_regfile;

  logic        clk;
  logic        resetn;
  logic [5:0]  int_i;
  logic [31:0] excepttype_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] bad_addr_i;
  logic [31:0] status_o, cause_o, epc_o, count_o, compare_o, badvaddr_o;
  logic        timer_int_o;

  cp0_regfile_if bus ();

  cp0_regfile dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus),
    .int_i          (int_i),
    .excepttype_i   (excepttype_i),
    .pc_i           (pc_i),
    .in_delayslot_i (in_delayslot_i),
    .bad_addr_i     (bad_addr_i),
    .status_o       (status_o),
    .cause_o        (cause_o),
    .epc_o          (epc_o),
    .count_o        (count_o),
    .compare_o      (compare_o),
    .badvaddr_o     (badvaddr_o),
    .timer_int_o    (timer_int_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Architectural model state
  logic [31:0] m_status, m_cause, m_epc, m_count, m_compare, m_badv;
  bit          m_tick, m_timer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count;
      5'd11:   return m_compare;
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return 32'h0000_4220;
      default: return 32'h0;
    endcase
  endfunction

  // Apply one clock edge's worth of architectural rules to the model.
  task automatic model_update();
    bit exc, eret, wr, hit;
    logic [31:0] nc;
    if (!resetn) begin
      m_status = 32'h0040_0000; m_cause = 0; m_epc = 0; m_count = 0;
      m_compare = 0; m_badv = 0; m_tick = 0; m_timer = 0;
      return;
    end
    exc  = excepttype_i inside {32'h1, 32'h4, 32'h5, 32'h8, 32'h9, 32'ha, 32'hc};
    eret = (excepttype_i == 32'he);
    wr   = bus.we_i && !exc && !eret;
    nc   = (wr && bus.waddr_i == 5'd9) ? bus.wdata_i : m_count + (m_tick ? 32'd1 : 32'd0);
    hit  = (nc == m_compare) && (m_compare != 0);
    m_cause[15:10] = {int_i[5] | m_timer, int_i[4:0]};
    if (wr && bus.waddr_i == 5'd11) begin
      m_compare = bus.wdata_i;
      m_timer   = 0;
    end else if (hit) begin
      m_timer = 1;
    end
    m_count = nc;
    m_tick  = !m_tick;
    if (wr && bus.waddr_i == 5'd12) m_status = (m_status & ~32'h0000_FF03) | (bus.wdata_i & 32'h0000_FF03);
    if (wr && bus.waddr_i == 5'd13) m_cause[9:8] = bus.wdata_i[9:8];
    if (wr && bus.waddr_i == 5'd14) m_epc = bus.wdata_i;
    if (exc) begin
      if (!m_status[1]) begin
        m_epc      = in_delayslot_i ? pc_i - 32'd4 : pc_i;
        m_cause[31] = in_delayslot_i;
      end
      m_status[1]  = 1'b1;
      m_cause[6:2] = (excepttype_i == 32'h1) ? 5'd0 : excepttype_i[4:0];
      if (excepttype_i == 32'h4 || excepttype_i == 32'h5) m_badv = bad_addr_i;
    end else if (eret) begin
      m_status[1] = 1'b0;
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("status",   status_o,    m_status);
      check("cause",    cause_o,     m_cause);
      check("epc",      epc_o,       m_epc);
      check("count",    count_o,     m_count);
      check("compare",  compare_o,   m_compare);
      check("badvaddr", badvaddr_o,  m_badv);
      check("timer_int", 32'(timer_int_o), 32'(m_timer));
      check("rdata",    bus.rdata_o, model_read(bus.raddr_i));
    end
  end

  task automatic step();
    @(posedge clk);
    model_update();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i = 0; excepttype_i = 0; pc_i = 0; in_delayslot_i = 0; bad_addr_i = 0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      bus.raddr_i = 5'($urandom_range(0, 31));
      step();
    end
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.we_i = 1; bus.waddr_i = a; bus.wdata_i = d;
    step();
    bus.we_i = 0;
  endtask

  task automatic except(input logic [31:0] code, input logic [31:0] pc,
                        input logic ds, input logic [31:0] bad);
    excepttype_i = code; pc_i = pc; in_delayslot_i = ds; bad_addr_i = bad;
    step();
    idle();
  endtask

  initial begin
    int k;
    resetn = 0; int_i = 0; bus.waddr_i = 0; bus.wdata_i = 0; bus.raddr_i = 0;
    idle();
    step(); step();

    // Reset values and read map
    check("rst_status", status_o, 32'h0040_0000);
    check("rst_epc", epc_o, 32'h0);
    check("rst_timer", 32'(timer_int_o), 32'h0);
    bus.raddr_i = 5'd15; #1;
    check("rd_prid", bus.rdata_o, 32'h0000_4220);
    bus.raddr_i = 5'd3; #1;
    check("rd_unmapped", bus.rdata_o, 32'h0);

    resetn = 1;
    run(10);
    check("count_after10", count_o, 32'd5);

    // Timer: Compare=8, Count=0, wait for the match
    mtc0(5'd11, 32'd8);
    mtc0(5'd9, 32'd0);
    k = 0;
    while (!timer_int_o && k < 40) begin
      run(1);
      k++;
    end
    check("timer_rise", 32'(timer_int_o), 32'h1);
    check("timer_count", count_o, 32'd8);
    run(1);
    check("cause_ti", 32'(cause_o[15]), 32'h1);
    mtc0(5'd11, 32'h100);
    check("timer_clear", 32'(timer_int_o), 32'h0);

    // Cause write mask and hardware interrupt sampling
    mtc0(5'd13, 32'hFFFF_FFFF);
    check("cause_wmask", cause_o, 32'h0000_0300);
    int_i = 6'b000001;
    run(1);
    check("cause_ip2", 32'(cause_o[10]), 32'h1);
    int_i = 0;
    run(1);

    // AdEL in a delay slot
    except(32'h4, 32'hBFC0_0100, 1'b1, 32'h1235);
    check("adel_epc", epc_o, 32'hBFC0_00FC);
    check("adel_bd", 32'(cause_o[31]), 32'h1);
    check("adel_code", 32'(cause_o[6:2]), 32'h4);
    check("adel_badv", badvaddr_o, 32'h1235);
    check("adel_exl", 32'(status_o[1]), 32'h1);
    except(32'he, 32'h0, 1'b0, 32'h0);
    check("eret_exl", 32'(status_o[1]), 32'h0);

    // Nested exception keeps EPC
    mtc0(5'd12, 32'h0000_0002);
    except(32'h8, 32'h2000, 1'b0, 32'h0);
    check("nest_epc", epc_o, 32'hBFC0_00FC);
    check("nest_code", 32'(cause_o[6:2]), 32'h8);
    except(32'he, 32'h0, 1'b0, 32'h0);

    // mtc0 squashed by a same-cycle exception
    bus.we_i = 1; bus.waddr_i = 5'd12; bus.wdata_i = 32'hFFFF_FFFF;
    except(32'hc, 32'h3000, 1'b0, 32'h0);
    check("squash_status", status_o, 32'h0040_0002);
    check("squash_epc", epc_o, 32'h3000);

    // Unknown code is no event; mtc0 goes through
    bus.we_i = 1; bus.waddr_i = 5'd14; bus.wdata_i = 32'h1234_5678;
    except(32'h3, 32'h4000, 1'b1, 32'h0);
    check("unknown_epc", epc_o, 32'h1234_5678);

    // Read-only BadVAddr, Count wrap, Int code maps to ExcCode 0
    mtc0(5'd8, 32'hDEAD);
    check("badv_ro", badvaddr_o, 32'h1235);
    except(32'he, 32'h0, 1'b0, 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    run(4);
    except(32'h1, 32'h5000, 1'b0, 32'h0);
    check("int_code", 32'(cause_o[6:2]), 32'h0);
    run(3);

    // Reset mid-operation beats everything else
    resetn = 0;
    bus.we_i = 1; bus.waddr_i = 5'd12; bus.wdata_i = 32'hFFFF_FFFF;
    except(32'h4, 32'h6000, 1'b1, 32'h77);
    check("mid_rst_status", status_o, 32'h0040_0000);
    check("mid_rst_count", count_o, 32'h0);
    resetn = 1;
    run(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
Coprocessor-0 register file for the MIPS core. It consumes the 32-bit exception type code from the exception prioritiser in the MEM stage. It also serves mfc0/mtc0 traffic.
- On an exception it commits EPC, Cause, Status and BadVAddr.
- It runs the Count/Compare timer.
- It feeds current Status/Cause back to the prioritiser and EPC to the PC-select logic.

Parameters:
STATUS_RST, 32'h0040_0000, Status reset value (BEV=1)
PRID_VAL, 32'h0000_4220, read-only PRId contents

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
we_i  in  1  mtc0 write enable
waddr_i  in  5  mtc0 register number
wdata_i  in  32  mtc0 write data
raddr_i  in  5  mfc0 register number
rdata_o  out  32  mfc0 read data (combinational)
int_i  in  6  external hardware interrupt lines
excepttype_i  in  32  code from prioritiser: 0 none, 1 Int, 4 AdEL, 5 AdES, 8 Sys, 9 Bp, a RI, c Ov, e eret
pc_i  in  32  PC of the excepting MEM-stage instruction
in_delayslot_i  in  1  excepting instruction is in a branch delay slot
bad_addr_i  in  32  faulting address for AdEL/AdES
status_o  out  32  Status register
cause_o  out  32  Cause register
epc_o  out  32  EPC register
count_o  out  32  Count register
compare_o  out  32  Compare register
badvaddr_o  out  32  BadVAddr register
timer_int_o  out  1  timer interrupt pending

Behaviour:
- Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC, 15 PRId. Reads of other numbers return 0.
- Reset (resetn=0 at clk edge):
  - Status=STATUS_RST.
  - Cause, EPC, Count, Compare, BadVAddr = 0.
  - timer_int_o=0; internal tick flop=0.
- Read: rdata_o is a pure function of raddr_i and current register state. There is no write-to-read bypass; the pipeline forwards.
- Count:
  - tick toggles every cycle; Count increments by 1 on cycles where tick==1 (half clock rate). Wraps 32'hFFFF_FFFF->0.
  - mtc0 Count overrides the increment that cycle.
- Timer:
  - timer_int_o sets on the edge where the next Count value equals Compare and Compare!=0.
  - It stays sticky until mtc0 Compare, which clears it and loads Compare. Clear wins over a same-cycle set.
- Cause.IP[7:2] (bits 15:10) is resampled every cycle as {int_i[5]|timer_int_o, int_i[4:0]}. Hardware owns these bits; mtc0 cannot write them.
- mtc0 write masks:
  - Status: only bits [15:8] (IM), [1] (EXL), [0] (IE).
  - Cause: only bits [9:8] (software IP).
  - EPC, Compare, Count: full 32 bits.
  - BadVAddr, PRId: read-only; writes ignored.
- Exception commit (excepttype_i != 0, not e), at clk edge:
  - If Status.EXL==0: EPC = in_delayslot_i ? pc_i-4 : pc_i, and Cause.BD(31) = in_delayslot_i.
  - If EXL==1: EPC and BD are unchanged.
  - Always: Status.EXL=1; Cause.ExcCode[6:2] = 0 for code 1, else the low 5 bits of the code.
  - Codes 4/5: BadVAddr = bad_addr_i.
- eret (excepttype_i == 32'h0000_000e): Status.EXL=0; no other state changes.
- Unknown nonzero codes: treated as no event.
- Simultaneous events:
  - An exception or eret in the same cycle as we_i blocks the whole mtc0 write. The excepting instruction's mtc0 is squashed.
  - Count increment and timer logic still run.
- Reset mid-operation restores all reset values next edge regardless of other inputs.
- Outputs status_o/cause_o/epc_o etc. are direct register values; all updates are visible the cycle after the edge.

Decomposition:
- Shared package cpu_defines: CP0 register numbers (CP0_BADVADDR..CP0_PRID), excepttype codes (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET), ExcCode values, Status/Cause bit indices and write masks.
- One natural sub-module: cp0_timer (tick flop, Count, Compare, timer_int with write overrides). The register file instantiates it and owns Status/Cause/EPC/BadVAddr.

Test Plan:
- Reset, then read all regs -> Status=0x0040_0000, others 0, PRId=0x0000_4220, timer_int_o=0. After 10 cycles, Count=5.
- mtc0 Compare=8 with Count at 0 -> timer_int_o rises on the edge Count becomes 8 and Cause[15]=1. mtc0 Compare=0x100 -> timer_int_o=0 next cycle.
- excepttype_i=0x4, pc_i=0xBFC0_0100, in_delayslot_i=1, bad_addr_i=0x1235:
  - EPC=0xBFC0_00FC, Cause[31]=1, ExcCode=4, BadVAddr=0x1235, Status.EXL=1.
  - A following eret -> EXL=0.
- With EXL=1, excepttype_i=0x8, pc_i=0x2000 -> EPC unchanged, ExcCode=8.
- we_i=1 to Status with 0xFFFF_FFFF in the same cycle as excepttype_i=0xc -> the write is dropped and only EXL is set.
- mtc0 Cause=0xFFFF_FFFF with int_i=0 -> Cause reads 0x0000_0300. Driving int_i=6'b000001 -> Cause[10]=1 next cycle.
